// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared widths and fetch FSM state encodings
package fetch_sequencer_pkg;

    localparam int WORD      = 32;
    localparam int INSTR_LEN = 32;

    // Fetch FSM encodings (3-bit, legacy-compatible)
    localparam logic [2:0] FS_IDLE = 3'd0;
    localparam logic [2:0] FS_REQ  = 3'd1;
    localparam logic [2:0] FS_WAIT = 3'd2;
    localparam logic [2:0] FS_HOLD = 3'd3;
    localparam logic [2:0] FS_DROP = 3'd4;

    // Redirect targets are forced word-aligned
    localparam logic [WORD-1:0] PC_ALIGN_MASK = {{(WORD-2){1'b1}}, 2'b00};

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch stage bus: branch redirect, imem request/response, decode handoff
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic                 pc_src;
    logic [WORD-1:0]      branch_target;
    logic                 dec_ready;
    logic                 imem_req;
    logic [WORD-1:0]      imem_addr;
    logic                 imem_valid;
    logic [INSTR_LEN-1:0] imem_rdata;
    logic                 out_valid;
    logic [INSTR_LEN-1:0] out_instr;
    logic [WORD-1:0]      out_pc;
    logic [WORD-1:0]      out_incr_pc;

    modport master (
        input  pc_src, branch_target, dec_ready, imem_valid, imem_rdata,
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_incr_pc
    );

    modport slave (
        output pc_src, branch_target, dec_ready, imem_valid, imem_rdata,
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_incr_pc
    );

endinterface

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating 32-bit event counter, present only with FETCH_PERF_CNT_EN
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Count events, sticking at all-ones instead of wrapping
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch stage PC/FSM owner; FETCH_PERF_CNT_EN adds fetch/drop counters
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [WORD-1:0] STEP     = WORD'(4),
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       drop_cnt
`endif
);

    logic [2:0]           state_q, state_d;
    logic [WORD-1:0]      pc_q, pc_d;
    logic [WORD-1:0]      pc_plus_step;
    logic                 out_valid_q, out_valid_d;
    logic [INSTR_LEN-1:0] out_instr_q, out_instr_d;
    logic [WORD-1:0]      out_pc_q, out_pc_d;
    logic [WORD-1:0]      out_incr_q, out_incr_d;
    logic                 redirect;

    // Single incrementer shared by the pc advance and out_incr_pc
    assign pc_plus_step = pc_q + STEP;

    // Redirects are ignored only in the first cycle after reset
    assign redirect = bus.pc_src && (state_q != FS_IDLE);

    // Next-state, pc and output-register logic
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_incr_d  = out_incr_q;
        case (state_q)
            FS_IDLE: state_d = FS_REQ;
            FS_REQ:  state_d = redirect ? FS_DROP : FS_WAIT;
            FS_WAIT: begin
                if (bus.imem_valid) begin
                    if (!redirect) begin
                        out_valid_d = 1'b1;
                        out_instr_d = bus.imem_rdata;
                        out_pc_d    = pc_q;
                        out_incr_d  = pc_plus_step;
                        pc_d        = pc_plus_step;
                        state_d     = FS_HOLD;
                    end else begin
                        state_d = FS_REQ;
                    end
                end else if (redirect) begin
                    state_d = FS_DROP;
                end
            end
            FS_HOLD: begin
                if (bus.dec_ready || redirect) begin
                    out_valid_d = 1'b0;
                    state_d     = FS_REQ;
                end
            end
            FS_DROP: begin
                if (bus.imem_valid) begin
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_IDLE;
        endcase
        // A redirect target always wins over the sequential pc
        if (redirect) begin
            pc_d = bus.branch_target & PC_ALIGN_MASK;
        end
    end

    // State, pc and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FS_IDLE;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_incr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_incr_q  <= out_incr_d;
        end
    end

    assign bus.imem_req    = (state_q == FS_REQ);
    assign bus.imem_addr   = (state_q == FS_REQ) ? pc_q : '0;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_incr_pc = out_incr_q;

`ifdef FETCH_PERF_CNT_EN
    logic consume;
    logic discard;

    assign consume = out_valid_q && bus.dec_ready;
    assign discard = bus.imem_valid &&
                     ((state_q == FS_DROP) || ((state_q == FS_WAIT) && redirect));

    fetch_perf_cnt u_fetch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (consume),
        .count (fetch_cnt)
    );

    fetch_perf_cnt u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (discard),
        .count (drop_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer (random + directed)
module tb_fetch_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if ifa();
    fetch_sequencer_if ifb();

    logic [31:0] fc_a, dc_a, fc_b, dc_b;

    fetch_sequencer #(.STEP(32'd4), .RESET_PC(32'd0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt (fc_a),
        .drop_cnt  (dc_a)
`endif
    );

    fetch_sequencer #(.STEP(32'd4), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt (fc_b),
        .drop_cnt  (dc_b)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model of the fetch protocol, in transaction terms
    bit          m_started, m_req_now, m_outst, m_stale, m_pres;
    logic [31:0] m_pc, m_ppc, m_pinstr;
    int          m_fetch, m_drop;

    // Stimulus knobs and memory responder
    bit          k_random, k_dr, k_src;
    int          k_lat;
    logic [31:0] k_tgt;
    int          cyc = 0;
    bit          pending;
    int          resp_at;
    logic [31:0] resp_data;

    bit          last_req, last_ov;
    logic [31:0] last_addr;
    int          n_ov = 0;
    logic [31:0] req_log[$];
    logic [31:0] acc_pc_log[$];
    logic [31:0] acc_incr_log[$];
    logic [31:0] b_log[$];
    bit          b_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        m_started = 0; m_req_now = 0; m_outst = 0; m_stale = 0; m_pres = 0;
        m_pc = 32'd0; m_ppc = 32'd0; m_pinstr = 32'd0; m_fetch = 0; m_drop = 0;
        pending = 0;
    endtask

    task automatic model_step(input bit dr, input bit src, input logic [31:0] tgt,
                              input bit vld, input logic [31:0] rd);
        logic [31:0] t;
        t = tgt & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1; m_req_now = 1;
        end else if (m_req_now) begin
            m_req_now = 0; m_outst = 1; m_stale = src;
            if (src) m_pc = t;
        end else if (m_outst) begin
            if (vld) begin
                m_outst = 0;
                if (m_stale || src) begin
                    m_drop++; m_req_now = 1;
                end else begin
                    m_pres = 1; m_ppc = m_pc; m_pinstr = rd; m_pc = m_pc + 32'd4;
                end
            end else if (src) begin
                m_stale = 1;
            end
            if (src) m_pc = t;
        end else if (m_pres) begin
            if (dr || src) begin
                if (dr) m_fetch++;
                m_pres = 0; m_req_now = 1;
            end
            if (src) m_pc = t;
        end
    endtask

    // One clock: compare at the negedge, drive inputs, advance model, wait next negedge
    task automatic cycle();
        bit dr, src, vld;
        logic [31:0] tgt, rd;
        int lat;
        chk("imem_req", 32'(ifa.imem_req), 32'(m_req_now));
        chk("imem_addr", ifa.imem_addr, m_req_now ? m_pc : 32'd0);
        chk("out_valid", 32'(ifa.out_valid), 32'(m_pres));
        if (m_pres) begin
            chk("out_pc", ifa.out_pc, m_ppc);
            chk("out_instr", ifa.out_instr, m_pinstr);
            chk("out_incr_pc", ifa.out_incr_pc, m_ppc + 32'd4);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fc_a, 32'(m_fetch));
        chk("drop_cnt", dc_a, 32'(m_drop));
`endif
        last_req  = ifa.imem_req;
        last_addr = ifa.imem_addr;
        last_ov   = ifa.out_valid;
        if (last_req) req_log.push_back(last_addr);
        if (last_ov) n_ov++;
        if (k_random) begin
            dr  = ($urandom_range(3) != 0);
            src = ($urandom_range(7) == 0);
            tgt = $urandom;
            lat = $urandom_range(3, 1);
        end else begin
            dr = k_dr; src = k_src; tgt = k_tgt; lat = k_lat;
        end
        vld = 0;
        rd  = $urandom;
        if (pending && cyc == resp_at) begin
            vld = 1; rd = resp_data; pending = 0;
        end else if (k_random && !pending && !last_req && $urandom_range(15) == 0) begin
            vld = 1;
        end
        if (last_req) begin
            pending = 1; resp_at = cyc + lat; resp_data = rdata_of(last_addr);
        end
        if (last_ov && dr) begin
            acc_pc_log.push_back(ifa.out_pc);
            acc_incr_log.push_back(ifa.out_incr_pc);
        end
        ifa.dec_ready = dr; ifa.pc_src = src; ifa.branch_target = tgt;
        ifa.imem_valid = vld; ifa.imem_rdata = rd;
        model_step(dr, src, tgt, vld, rd);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        do begin cycle(); n++; end while (!last_req && n < 40);
        if (!last_req) begin
            checks++; failures++;
            $display("FAIL %s timeout actual=no_request required=request", nm);
        end
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        do begin cycle(); n++; end while (!last_ov && n < 40);
        if (!last_ov) begin
            checks++; failures++;
            $display("FAIL %s timeout actual=no_out_valid required=out_valid", nm);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ifa.dec_ready = 0; ifa.pc_src = 0; ifa.branch_target = 0;
        ifa.imem_valid = 0; ifa.imem_rdata = 0;
        model_reset();
        req_log.delete(); acc_pc_log.delete(); acc_incr_log.delete();
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(ifa.imem_req), 32'd0);
        chk("rst_imem_addr", ifa.imem_addr, 32'd0);
        chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_out_pc", ifa.out_pc, 32'd0);
        chk("rst_out_incr_pc", ifa.out_incr_pc, 32'd0);
        reset = 1'b1;
    endtask

    // Instance B: fixed latency-1 memory, decode always ready
    always @(negedge clk) begin
        ifb.imem_valid = b_prev;
        ifb.imem_rdata = 32'h0000_1234;
        b_prev = ifb.imem_req;
        if (ifb.imem_req) b_log.push_back(ifb.imem_addr);
        if (!reset) begin
            b_log.delete(); b_prev = 1'b0; ifb.imem_valid = 1'b0;
        end
    end

    initial begin
        int d0, f0, v0, r0;
        ifb.dec_ready = 1; ifb.pc_src = 0; ifb.branch_target = 0;
        k_random = 0; k_lat = 1; k_dr = 1; k_src = 0; k_tgt = 0;
        do_reset();

        // Sequential fetch, latency 1, decode ready
        begin
            int n = 0;
            while (acc_pc_log.size() < 3 && n < 40) begin cycle(); n++; end
        end
        chk("t1_req_count", 32'(req_log.size() >= 3), 32'd1);
        chk("t1_addr0", req_log[0], 32'h0);
        chk("t1_addr1", req_log[1], 32'h4);
        chk("t1_addr2", req_log[2], 32'h8);
        chk("t1_pc0", acc_pc_log[0], 32'h0);
        chk("t1_pc1", acc_pc_log[1], 32'h4);
        chk("t1_pc2", acc_pc_log[2], 32'h8);
        chk("t1_incr0", acc_incr_log[0], 32'h4);
        chk("t1_incr1", acc_incr_log[1], 32'h8);
        chk("t1_incr2", acc_incr_log[2], 32'hC);

        // Wrap from RESET_PC = 0xFFFF_FFFC on instance B
        chk("t5_b_req_count", 32'(b_log.size() >= 2), 32'd1);
        chk("t5_b_addr0", b_log[0], 32'hFFFF_FFFC);
        chk("t5_b_addr1", b_log[1], 32'h0);

        // Decode stall in HOLD
        k_dr = 0;
        wait_valid("t2_valid");
        chk("t2_hold_pc", ifa.out_pc, 32'hC);
        r0 = req_log.size();
        repeat (5) cycle();
        chk("t2_no_req", 32'(req_log.size() - r0), 32'd0);
        k_dr = 1;
        wait_req("t2_req");
        chk("t2_next_addr", last_addr, 32'h10);

        // Redirect during WAIT, latency 3
        k_lat = 3;
        wait_req("t3_req");
        chk("t3_req_addr", last_addr, 32'h14);
        d0 = 0;
`ifdef FETCH_PERF_CNT_EN
        d0 = int'(dc_a);
`endif
        v0 = n_ov;
        k_src = 1; k_tgt = 32'h103;
        cycle();
        k_src = 0;
        wait_req("t3_redirect_req");
        chk("t3_next_addr", last_addr, 32'h100);
        chk("t3_no_out_valid", 32'(n_ov - v0), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("t3_drop_delta", dc_a - 32'(d0), 32'd1);
`endif

        // Redirect together with dec_ready in HOLD
        k_lat = 1; k_dr = 0;
        wait_valid("t4a_valid");
        chk("t4a_hold_pc", ifa.out_pc, 32'h100);
        k_dr = 1; k_src = 1; k_tgt = 32'h20;
        cycle();
        k_src = 0;
        wait_req("t4a_req");
        chk("t4a_next_addr", last_addr, 32'h20);
        k_dr = 0;
        wait_valid("t4b_valid");
        chk("t4b_hold_pc", ifa.out_pc, 32'h20);
        f0 = 0;
`ifdef FETCH_PERF_CNT_EN
        f0 = int'(fc_a);
`endif
        k_dr = 1; k_src = 1; k_tgt = 32'h80;
        cycle();
        k_src = 0;
`ifdef FETCH_PERF_CNT_EN
        chk("t4b_fetch_delta", fc_a - 32'(f0), 32'd1);
`endif
        wait_req("t4b_req");
        chk("t4b_next_addr", last_addr, 32'h80);

        // Randomized traffic against the model
        k_random = 1;
        repeat (3000) cycle();
        k_random = 0; k_dr = 1; k_src = 0; k_lat = 3;

        // Reset asserted while a request is in flight
        wait_req("t6_req");
        #2 reset = 1'b0;
        #1;
        chk("t6_imem_req", 32'(ifa.imem_req), 32'd0);
        chk("t6_imem_addr", ifa.imem_addr, 32'd0);
        chk("t6_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("t6_out_pc", ifa.out_pc, 32'd0);
        chk("t6_out_instr", ifa.out_instr, 32'd0);
        chk("t6_out_incr_pc", ifa.out_incr_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_fetch_cnt", fc_a, 32'd0);
        chk("t6_drop_cnt", dc_a, 32'd0);
`endif
        @(negedge clk);
        do_reset();
        wait_req("t6_first_req");
        chk("t6_first_addr", last_addr, 32'h0);
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
